// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle MIPS controller and its datapath.
// The controller drives the datapath enables, the mux selects and the ALU opcode.
// It consumes the instruction fields and the ALU Zero flag.
interface mips_multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       Opcode;
    logic [5:0]       Funct;
    logic             Zero;
    logic             PCEn;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             MemtoReg;
    logic             RegDst;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       PCSource;
    logic [3:0]       ALUOperation;
    logic             IllegalOp;
    logic [3:0]       State;
    logic [CNT_W-1:0] InstrCount;

    modport master (
        input  Opcode, Funct, Zero,
        output PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
               ALUSrcA, ALUSrcB, PCSource, ALUOperation, IllegalOp, State, InstrCount
    );

    modport slave (
        output Opcode, Funct, Zero,
        input  PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
               ALUSrcA, ALUSrcB, PCSource, ALUOperation, IllegalOp, State, InstrCount
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller.
// It sequences fetch/decode/execute/memory/writeback for R-type, lw, sw, beq, j and addi.
// Outputs are Moore-decoded from the registered state.
module mips_multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input logic                  clk,
    input logic                  reset,
    mips_multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        RTYPE_EX = 4'd6,
        RTYPE_WB = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11
    } state_t;

    state_t           state;
    logic [5:0]       op_q;
    logic [5:0]       funct_q;
    logic [CNT_W-1:0] count;
    logic             retire;
    logic             op_legal;
    logic [3:0]       rt_aluop;
    logic             rt_legal;

    logic             pcen, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite;
    logic             alusrca, illegal;
    logic [1:0]       alusrcb, pcsource;
    logic [3:0]       aluop;

    // States whose exit edge completes an instruction
    always_comb begin
        retire = 1'b0;
        case (state)
            MEMWB, MEMWRITE, RTYPE_WB, BRANCH, JUMP, ADDI_WB: retire = 1'b1;
            default:                                          retire = 1'b0;
        endcase
    end

    // Opcode legality, judged on the live opcode during DECODE
    always_comb begin
        op_legal = 1'b0;
        case (bus.Opcode)
            6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08: op_legal = 1'b1;
            default:                                   op_legal = 1'b0;
        endcase
    end

    // R-type funct to ALU opcode, from the latched funct
    always_comb begin
        rt_aluop = 4'b0000;
        rt_legal = 1'b1;
        case (funct_q)
            6'h20:   rt_aluop = 4'b0010;
            6'h22:   rt_aluop = 4'b0110;
            6'h24:   rt_aluop = 4'b0000;
            6'h25:   rt_aluop = 4'b0001;
            6'h27:   rt_aluop = 4'b1100;
            6'h2A:   rt_aluop = 4'b0111;
            default: rt_legal = 1'b0;
        endcase
    end

    // State register, instruction-field latches and retired-instruction counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            op_q    <= '0;
            funct_q <= '0;
            count   <= '0;
        end else begin
            if (retire) begin
                count <= count + CNT_W'(1);
            end
            case (state)
                FETCH:    state <= DECODE;
                DECODE: begin
                    op_q    <= bus.Opcode;
                    funct_q <= bus.Funct;
                    case (bus.Opcode)
                        6'h00:        state <= RTYPE_EX;
                        6'h23, 6'h2B: state <= MEMADR;
                        6'h04:        state <= BRANCH;
                        6'h02:        state <= JUMP;
                        6'h08:        state <= ADDI_EX;
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR:   state <= (op_q == 6'h23) ? MEMREAD : MEMWRITE;
                MEMREAD:  state <= MEMWB;
                RTYPE_EX: state <= rt_legal ? RTYPE_WB : FETCH;
                ADDI_EX:  state <= ADDI_WB;
                default:  state <= FETCH;
            endcase
        end
    end

    // Moore output decode.
    // Gating with reset drops the write enables asynchronously.
    // It also lets FETCH outputs show up as soon as reset releases.
    always_comb begin
        pcen     = 1'b0;
        iord     = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsource = 2'b00;
        aluop    = 4'b0000;
        illegal  = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    memread = 1'b1;
                    irwrite = 1'b1;
                    alusrcb = 2'b01;
                    aluop   = 4'b0010;
                    pcen    = 1'b1;
                end
                DECODE: begin
                    alusrcb = 2'b11;
                    aluop   = 4'b0010;
                    illegal = ~op_legal;
                end
                MEMADR, ADDI_EX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    aluop   = 4'b0010;
                end
                MEMREAD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                MEMWRITE: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                RTYPE_EX: begin
                    alusrca = 1'b1;
                    aluop   = rt_aluop;
                    illegal = ~rt_legal;
                end
                RTYPE_WB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                BRANCH: begin
                    alusrca  = 1'b1;
                    aluop    = 4'b0110;
                    pcsource = 2'b01;
                    pcen     = bus.Zero;
                end
                JUMP: begin
                    pcsource = 2'b10;
                    pcen     = 1'b1;
                end
                ADDI_WB: begin
                    regwrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.PCEn         = pcen;
    assign bus.IorD         = iord;
    assign bus.MemRead      = memread;
    assign bus.MemWrite     = memwrite;
    assign bus.IRWrite      = irwrite;
    assign bus.MemtoReg     = memtoreg;
    assign bus.RegDst       = regdst;
    assign bus.RegWrite     = regwrite;
    assign bus.ALUSrcA      = alusrca;
    assign bus.ALUSrcB      = alusrcb;
    assign bus.PCSource     = pcsource;
    assign bus.ALUOperation = aluop;
    assign bus.IllegalOp    = illegal;
    assign bus.State        = state;
    assign bus.InstrCount   = count;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl.
// It runs directed and random instructions against a per-instruction state-sequence model.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsource;
        logic [3:0] aluop;
        logic       illegal;
    } ctrl_t;

    logic        clk;
    logic        reset;
    int unsigned n_cmp;
    int unsigned n_fail;
    int unsigned cnt;

    mips_multicycle_ctrl_if #(.CNT_W(32)) ifc ();
    mips_multicycle_ctrl_if #(.CNT_W(4))  if4 ();

    mips_multicycle_ctrl #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.master)
    );

    mips_multicycle_ctrl #(.CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4.master)
    );

    assign if4.Opcode = ifc.Opcode;
    assign if4.Funct  = ifc.Funct;
    assign if4.Zero   = ifc.Zero;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic legal_fn(input logic [5:0] fn);
        return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    endfunction

    function automatic logic legal_op(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    endfunction

    function automatic logic [3:0] fn_alu(input logic [5:0] fn);
        case (fn)
            6'h20:   return 4'b0010;
            6'h22:   return 4'b0110;
            6'h25:   return 4'b0001;
            6'h27:   return 4'b1100;
            6'h2A:   return 4'b0111;
            default: return 4'b0000;
        endcase
    endfunction

    // Expected control word for a state number of the instruction being modelled
    function automatic ctrl_t exp_ctrl(input int s, input logic [5:0] op, input logic [5:0] fn,
                                       input logic z);
        ctrl_t c;
        c = '0;
        case (s)
            0:  begin c.memread = 1; c.irwrite = 1; c.alusrcb = 2'b01; c.aluop = 4'b0010; c.pcen = 1; end
            1:  begin c.alusrcb = 2'b11; c.aluop = 4'b0010; c.illegal = ~legal_op(op); end
            2, 10: begin c.alusrca = 1; c.alusrcb = 2'b10; c.aluop = 4'b0010; end
            3:  begin c.memread = 1; c.iord = 1; end
            4:  begin c.regwrite = 1; c.memtoreg = 1; end
            5:  begin c.memwrite = 1; c.iord = 1; end
            6:  begin c.alusrca = 1; c.aluop = fn_alu(fn); c.illegal = ~legal_fn(fn); end
            7:  begin c.regwrite = 1; c.regdst = 1; end
            8:  begin c.alusrca = 1; c.aluop = 4'b0110; c.pcsource = 2'b01; c.pcen = z; end
            9:  begin c.pcsource = 2'b10; c.pcen = 1; end
            11: begin c.regwrite = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ctrl_t obs_ctrl();
        return {ifc.PCEn, ifc.IorD, ifc.MemRead, ifc.MemWrite, ifc.IRWrite, ifc.MemtoReg,
                ifc.RegDst, ifc.RegWrite, ifc.ALUSrcA, ifc.ALUSrcB, ifc.PCSource,
                ifc.ALUOperation, ifc.IllegalOp};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_counts();
        check("count", ifc.InstrCount, cnt);
        check("count4", 32'(if4.InstrCount), cnt % 16);
    endtask

    // Runs one instruction starting in FETCH just after a falling edge.
    // zf < 0 gives a random Zero each cycle.
    // abort_at >= 0 asserts reset during that step of the sequence.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zf,
                             input int abort_at);
        int  seq[$];
        bit  ret;
        bit  aborted;
        logic z;
        seq = '{0, 1};
        ret = 1'b1;
        aborted = 1'b0;
        case (op)
            6'h00: begin
                seq.push_back(6);
                if (legal_fn(fn)) seq.push_back(7);
                else ret = 1'b0;
            end
            6'h23: begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
            6'h2B: begin seq.push_back(2); seq.push_back(5); end
            6'h04: seq.push_back(8);
            6'h02: seq.push_back(9);
            6'h08: begin seq.push_back(10); seq.push_back(11); end
            default: ret = 1'b0;
        endcase
        ifc.Opcode = op;
        ifc.Funct  = fn;
        for (int i = 0; i < seq.size(); i++) begin
            if (i > 0) @(negedge clk);
            z = (zf < 0) ? 1'($urandom) : zf[0];
            ifc.Zero = z;
            if (i >= 2) begin
                ifc.Opcode = 6'h02;
                ifc.Funct  = 6'($urandom);
            end
            #1;
            check($sformatf("state op%0h s%0d", op, i), 32'(ifc.State), 32'(seq[i]));
            check($sformatf("ctrl op%0h st%0d", op, seq[i]), 32'(obs_ctrl()),
                  32'(exp_ctrl(seq[i], op, fn, z)));
            check_counts();
            if (i == abort_at) begin
                #1 reset = 1'b1;
                #1;
                check("rst memwrite", 32'(ifc.MemWrite), 32'd0);
                check("rst ctrl", 32'(obs_ctrl()), 32'd0);
                check("rst state", 32'(ifc.State), 32'd0);
                cnt = 0;
                check_counts();
                @(negedge clk);
                reset = 1'b0;
                #1;
                check("post-rst state", 32'(ifc.State), 32'd0);
                check("post-rst ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(0, op, fn, 1'b0)));
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            @(negedge clk);
            if (ret) cnt++;
        end
    endtask

    initial begin
        logic [5:0] ops[7];
        logic [5:0] fns[6];
        logic [5:0] op;
        logic [5:0] fn;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        n_cmp  = 0;
        n_fail = 0;
        cnt    = 0;
        reset      = 1'b1;
        ifc.Opcode = '0;
        ifc.Funct  = '0;
        ifc.Zero   = 1'b1;
        #7;
        check("reset state", 32'(ifc.State), 32'd0);
        check("reset ctrl", 32'(obs_ctrl()), 32'd0);
        check_counts();
        @(negedge clk);
        reset = 1'b0;

        run_instr(6'h23, 6'h00, -1, -1);
        for (int i = 0; i < 6; i++) run_instr(6'h00, fns[i], -1, -1);
        run_instr(6'h04, 6'h00, 1, -1);
        run_instr(6'h04, 6'h00, 0, -1);
        run_instr(6'h3F, 6'h20, -1, -1);
        run_instr(6'h00, 6'h00, -1, -1);
        run_instr(6'h2B, 6'h00, -1, 3);
        run_instr(6'h08, 6'h11, -1, -1);
        run_instr(6'h02, 6'h00, -1, -1);

        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 6)];
            if (op == 6'h3F) op = 6'($urandom);
            fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
            run_instr(op, fn, -1, -1);
        end
        #1;
        check_counts();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multicycle MIPS main controller. It is the initiator side of the ALU interface: it issues ALUOperation codes and operand-source selects, and consumes the ALU Zero flag. It sequences fetch/decode/execute/memory/writeback for R-type, lw, sw, beq, j and addi, and drives all datapath enables. Outputs are Moore-decoded from the registered state, so they are stable for the whole cycle; the ALU evaluates during the clock-high phase.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-high
Opcode  in  6  IR[31:26]
Funct  in  6  IR[5:0]
Zero  in  1  ALU Zero flag
PCEn  out  1  PC write enable
IorD  out  1  memory address select: 0=PC, 1=ALUOut
MemRead  out  1  memory read
MemWrite  out  1  memory write
IRWrite  out  1  instruction register load
MemtoReg  out  1  register write data: 0=ALUOut, 1=MDR
RegDst  out  1  destination register: 0=rt, 1=rd
RegWrite  out  1  register file write
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
ALUOperation  out  4  ALU opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
IllegalOp  out  1  one-cycle pulse on unsupported opcode or funct
State  out  4  current state (debug)
InstrCount  out  CNT_W  retired instructions

Behaviour:
- Clock is clk, rising edge. Reset is asynchronous and active-high.
- While reset is high: State=FETCH(0), InstrCount=0, internal op/funct registers=0, and every other output is forced to 0, including PCEn.
- After reset releases, the first rising edge begins in FETCH.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, RTYPE_EX=6, RTYPE_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11.
- Codes 12-15 drive all outputs to 0 and go to FETCH next.
- Opcode and Funct are latched into internal registers at the end of DECODE. Later states use only the latched values.
- Any output not listed for a state is 0.
- FETCH: MemRead=1, IRWrite=1, ALUSrcB=01, ALUOperation=0010, PCEn=1. Next: DECODE.
- DECODE: ALUSrcB=11, ALUOperation=0010 (branch target computed into ALUOut). Next state by Opcode:
  - 0x00 -> RTYPE_EX
  - 0x23 or 0x2B -> MEMADR
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - 0x08 -> ADDI_EX
  - any other opcode -> FETCH, with IllegalOp=1 this cycle; not counted as retired.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOperation=0010. Next: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: MemRead=1, IorD=1. Next: MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Retires. Next: FETCH.
- MEMWRITE: MemWrite=1, IorD=1. Retires. Next: FETCH.
- RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOperation from latched funct:
  - 0x20 -> 0010, 0x22 -> 0110, 0x24 -> 0000, 0x25 -> 0001, 0x27 -> 1100, 0x2A -> 0111
  - Supported funct: next RTYPE_WB.
  - Unsupported funct: ALUOperation=0000, IllegalOp=1, next FETCH, no writeback, not retired.
- RTYPE_WB: RegWrite=1, RegDst=1, MemtoReg=0. Retires. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOperation=0110, PCSource=01, PCEn=Zero (combinational within the cycle). Retires whether taken or not. Next: FETCH.
- JUMP: PCSource=10, PCEn=1. Retires. Next: FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOperation=0010. Next: ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0. Retires. Next: FETCH.
- Cycle counts: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- InstrCount increments by 1 on the rising edge that leaves a retiring state. It wraps modulo 2^CNT_W with no saturation.
- Reset asserted mid-instruction: immediate return to FETCH with outputs zeroed. No partial write may occur after reset asserts, i.e. RegWrite, MemWrite and PCEn drop asynchronously.
- Opcode and Funct changing after DECODE have no effect on the instruction in flight.

Test Plan:
- Reset, then Opcode=0x23 (lw) -> States 0,1,2,3,4,0. MEMREAD has IorD=1, MemRead=1; MEMWB has RegWrite=1, MemtoReg=1; InstrCount=1.
- R-type, Funct=0x2A -> RTYPE_EX shows ALUOperation=0111, ALUSrcA=1, ALUSrcB=00. RTYPE_WB has RegDst=1, RegWrite=1. Repeat for funct 0x20/22/24/25/27 -> 0010/0110/0000/0001/1100.
- beq with Zero=1 in BRANCH -> PCEn=1, PCSource=01. Second beq with Zero=0 -> PCEn=0. Both take 3 cycles; InstrCount advances by 2.
- Opcode=0x3F -> IllegalOp pulses high for 1 cycle in DECODE, next state FETCH, InstrCount unchanged. R-type with Funct=0x00 -> IllegalOp in RTYPE_EX, no RegWrite.
- Assert reset during MEMWRITE of sw -> MemWrite falls without waiting for a clock edge, State=0, InstrCount=0. After release, FETCH outputs appear with PCEn=1.
- Change Opcode to 0x02 during ADDI_EX of addi -> state still goes to ADDI_WB, not JUMP. Preload a counter with CNT_W=4 through 16 retirements -> InstrCount wraps to 0.
